// File: rtl/biriscv_fetch_pkg.sv
// Shared types for the fetch unpack stage: buffered fetch-word entry and
// the half-select used to walk its two instructions.
package biriscv_fetch_pkg;

    localparam int FETCH_PC_W = 29;

    typedef enum logic {
        HALF_LO = 1'b0,
        HALF_HI = 1'b1
    } half_e;

    typedef struct packed {
        logic [63:0]           data;
        logic [FETCH_PC_W-1:0] pc;
        half_e                 start;
        logic                  error;
    } fetch_entry_t;

    // Errored words carry no usable instruction bits
    function automatic logic [31:0] entry_instr(fetch_entry_t e, half_e h);
        if (e.error)
            return 32'h0;
        return (h == HALF_HI) ? e.data[63:32] : e.data[31:0];
    endfunction

endpackage

// File: rtl/biriscv_fetch_fifo.sv
// Generic circular push/pop FIFO with wrapping pointers and a flush.
// Storage is unreset; the head is only meaningful while valid is high.
module biriscv_fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/biriscv_fetch_unpack.sv
// Splits buffered 64-bit fetch words into 32-bit instructions.
// Optional handshake counter port: FETCH_UNPACK_STATS_EN.
module biriscv_fetch_unpack
    import biriscv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [63:0] fetch_data,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_error,
    output logic        fetch_accept,
    input  logic        flush,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        instr_fault,
    input  logic        instr_ready
`ifdef FETCH_UNPACK_STATS_EN
    ,
    output logic [31:0] instr_count
`endif
);

    localparam int EW = $bits(fetch_entry_t);

    fetch_entry_t   push_entry;
    fetch_entry_t   head;
    logic [EW-1:0]  head_raw;
    logic           head_valid;
    logic           full;
    logic           push;
    logic           pop;
    logic           hs;
    half_e          half_q;
    half_e          half_sel;
    logic           unused_pc;

    assign unused_pc    = ^fetch_pc[1:0];
    assign fetch_accept = !full && !flush;
    assign push         = fetch_valid && fetch_accept;

    always_comb begin
        push_entry       = '0;
        push_entry.data  = fetch_data;
        push_entry.pc    = fetch_pc[31:3];
        push_entry.start = half_e'(fetch_pc[2]);
        push_entry.error = fetch_error;
    end

    biriscv_fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_raw),
        .valid     (head_valid),
        .full      (full)
    );

    assign head = head_raw;

    // half_q only records that the lower half of the head was consumed
    assign half_sel = (head.start == HALF_HI || half_q == HALF_HI)
                    ? HALF_HI : HALF_LO;
    assign hs  = head_valid && instr_ready && !flush;
    assign pop = hs && (head.error || half_sel == HALF_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            half_q <= HALF_LO;
        else if (flush || pop)
            half_q <= HALF_LO;
        else if (hs)
            half_q <= HALF_HI;
    end

    always_comb begin
        instr_valid = head_valid;
        instr_data  = 32'h0;
        instr_pc    = 32'h0;
        instr_fault = 1'b0;
        if (head_valid) begin
            instr_data  = entry_instr(head, half_sel);
            instr_pc    = {head.pc, half_sel, 2'b00};
            instr_fault = head.error;
        end
    end

`ifdef FETCH_UNPACK_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            instr_count <= 32'h0;
        else if (hs)
            instr_count <= instr_count + 32'h1;
    end
`endif

endmodule

// File: tb/tb_biriscv_fetch_unpack.sv
// Directed and random checks of biriscv_fetch_unpack against a queue
// model of the instruction stream each fetch word expands into.
module tb_biriscv_fetch_unpack;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [63:0] fetch_data = '0;
    logic [31:0] fetch_pc = '0;
    logic        fetch_error = 1'b0;
    logic        fetch_accept;
    logic        flush = 1'b0;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_fault;
    logic        instr_ready = 1'b0;
`ifdef FETCH_UNPACK_STATS_EN
    logic [31:0] instr_count;
`endif

    biriscv_fetch_unpack #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_valid  (fetch_valid),
        .fetch_data   (fetch_data),
        .fetch_pc     (fetch_pc),
        .fetch_error  (fetch_error),
        .fetch_accept (fetch_accept),
        .flush        (flush),
        .instr_valid  (instr_valid),
        .instr_data   (instr_data),
        .instr_pc     (instr_pc),
        .instr_fault  (instr_fault),
        .instr_ready  (instr_ready)
`ifdef FETCH_UNPACK_STATS_EN
        ,
        .instr_count  (instr_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [31:0] p;
        logic        f;
        logic        last;
    } ins_t;

    ins_t q[$];
    int   total = 0;
    int   passed = 0;
    int   exp_cnt = 0;
    bit   last_acc = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int words();
        int n = 0;
        foreach (q[i]) if (q[i].last) n++;
        return n;
    endfunction

    function automatic void expand(logic [31:0] pc, logic [63:0] d, logic e);
        logic [31:0] base;
        base = {pc[31:3], 3'b000};
        if (e)
            q.push_back('{32'h0, {pc[31:2], 2'b00}, 1'b1, 1'b1});
        else if (pc[2])
            q.push_back('{d[63:32], base + 32'd4, 1'b0, 1'b1});
        else begin
            q.push_back('{d[31:0], base, 1'b0, 1'b0});
            q.push_back('{d[63:32], base + 32'd4, 1'b0, 1'b1});
        end
    endfunction

    task automatic step();
        bit acc_exp;
        #1;
        acc_exp = (words() < DEPTH) && !flush;
        chk("accept", fetch_accept, acc_exp);
        chk("valid", instr_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("data", instr_data, q[0].d);
            chk("pc", instr_pc, q[0].p);
            chk("fault", instr_fault, q[0].f);
        end
`ifdef FETCH_UNPACK_STATS_EN
        chk("count", instr_count, exp_cnt);
`endif
        last_acc = fetch_valid && acc_exp;
        if (flush)
            q.delete();
        else begin
            if (q.size() > 0 && instr_ready) begin
                void'(q.pop_front());
                exp_cnt++;
            end
            if (last_acc)
                expand(fetch_pc, fetch_data, fetch_error);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(logic [31:0] pc, logic [63:0] d, logic e);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        fetch_data  = d;
        fetch_error = e;
        for (int k = 0; k < 20; k++) begin
            step();
            if (last_acc) break;
        end
        if (!last_acc)
            chk("send_timeout", 1'b0, 1'b1);
        fetch_valid = 1'b0;
        fetch_error = 1'b0;
    endtask

    task automatic do_reset();
        fetch_valid = 1'b0;
        fetch_error = 1'b0;
        flush       = 1'b0;
        instr_ready = 1'b0;
        rst         = 1'b1;
        q.delete();
        exp_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_data", instr_data, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_fault", instr_fault, 1'b0);
        chk("rst_accept", fetch_accept, 1'b1);
`ifdef FETCH_UNPACK_STATS_EN
        chk("rst_count", instr_count, 32'h0);
`endif
    endtask

    initial begin
        do_reset();

        // aligned word, both halves on consecutive cycles
        instr_ready = 1'b1;
        send(32'h8000_0000, 64'h00000013_00100093, 1'b0);
        chk("lat1", instr_valid, 1'b1);
        step();
        step();
        step();

        // upper-half only
        send(32'h8000_0004, 64'hDEADBEEF_12345678, 1'b0);
        step();
        step();

        // backpressure: fill, stall, drain, third word accepted
        instr_ready = 1'b0;
        send(32'h0000_0100, 64'h11111111_22222222, 1'b0);
        send(32'h0000_0108, 64'h33333333_44444444, 1'b0);
        fetch_valid = 1'b1;
        fetch_pc    = 32'h0000_0110;
        fetch_data  = 64'h55555555_66666666;
        step();
        step();
        step();
        instr_ready = 1'b1;
        send(32'h0000_0110, 64'h55555555_66666666, 1'b0);
        repeat (6) step();

        // errored fetch then normal word
        send(32'h0000_1000, 64'hAAAAAAAA_BBBBBBBB, 1'b1);
        send(32'h0000_1008, 64'hCCCCCCCC_DDDDDDDD, 1'b0);
        repeat (4) step();

        // flush with two words held and a same-cycle push
        instr_ready = 1'b0;
        send(32'h0000_3000, 64'h01010101_02020202, 1'b0);
        send(32'h0000_3008, 64'h03030303_04040404, 1'b0);
        fetch_valid = 1'b1;
        fetch_pc    = 32'h0000_3010;
        flush       = 1'b1;
        step();
        flush       = 1'b0;
        fetch_valid = 1'b0;
        step();
        instr_ready = 1'b1;
        send(32'h0000_2000, 64'h0000AAAA_0000BBBB, 1'b0);
        repeat (3) step();

        // reset mid-operation drops held entries at once
        instr_ready = 1'b0;
        send(32'h0000_4000, 64'h77777777_88888888, 1'b0);
        send(32'h0000_4008, 64'h99999999_AAAAAAAA, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_valid", instr_valid, 1'b0);
        chk("midrst_fault", instr_fault, 1'b0);
        do_reset();

`ifdef FETCH_UNPACK_STATS_EN
        instr_ready = 1'b1;
        send(32'h0000_0000, 64'h1, 1'b0);
        send(32'h0000_0008, 64'h2, 1'b0);
        send(32'h0000_0014, 64'h3, 1'b0);
        repeat (4) step();
        #1;
        chk("count5", instr_count, 32'd5);
        do_reset();
`endif

        // random traffic
        for (int i = 0; i < 600; i++) begin
            fetch_valid = 1'($urandom);
            instr_ready = 1'($urandom);
            flush       = ($urandom_range(0, 24) == 0);
            fetch_error = ($urandom_range(0, 7) == 0);
            fetch_pc    = $urandom;
            fetch_data  = {$urandom, $urandom};
            step();
        end
        flush       = 1'b0;
        fetch_valid = 1'b0;
        instr_ready = 1'b1;
        repeat (8) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/biriscv_fetch_unpack.md
BIRISCV_FETCH_UNPACK -- requirements
Module: biriscv_fetch_unpack

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of 64-bit fetch-word entries buffered (legal values 2, 4, 8).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port fetch_valid  input  1  a fetch word is presented.
REQ-005 SHALL have port fetch_data  input  64  two instructions: [31:0] at PC, [63:32] at PC+4.
REQ-006 SHALL have port fetch_pc  input  32  byte address of the fetch word; bits [1:0] are ignored.
REQ-007 SHALL have port fetch_error  input  1  the fetch faulted.
REQ-008 SHALL have port fetch_accept  output  1  the word is taken this cycle when fetch_valid is high.
REQ-009 SHALL have port flush  input  1  discard all buffered and in-flight instructions.
REQ-010 SHALL have port instr_valid  output  1  an instruction is presented.
REQ-011 SHALL have port instr_data  output  32  the instruction word.
REQ-012 SHALL have port instr_pc  output  32  the instruction address, word aligned.
REQ-013 SHALL have port instr_fault  output  1  the instruction came from an errored fetch.
REQ-014 SHALL have port instr_ready  input  1  the consumer takes the instruction when instr_valid is also high.

Function
REQ-015 SHALL store each accepted word as {data, pc[31:3], start half, error} in a circular FIFO with DEPTH entries and wrapping read/write pointers.
REQ-016 SHALL drive fetch_accept = (occupancy < DEPTH) && !flush, with no combinational path from instr_ready.
REQ-017 SHALL set start half = fetch_pc[2], so a word fetched at PC 0x...4 issues only its upper instruction.
REQ-018 SHALL present the head entry's current half on the instr_* outputs; instr_pc = {pc[31:3], half, 2'b00}.
REQ-019 SHALL, on an instr_valid && instr_ready handshake, advance from the lower to the upper half, or pop the entry when the upper half is taken.
REQ-020 SHALL, for an errored entry, issue exactly one instruction with instr_fault=1 and data 0, then pop the entry; the second half is never issued.
REQ-021 SHALL have a latency of one cycle: a word accepted in cycle N is visible on instr_valid in cycle N+1 when the FIFO was empty.
REQ-022 SHALL hold the instr_* outputs stable while instr_valid=1 and instr_ready=0.
REQ-023 SHALL allow a push and a pop in the same cycle; occupancy is then unchanged.
REQ-024 SHALL, on flush, empty the FIFO, drop any same-cycle fetch, and drive instr_valid=0 in the following cycle.
REQ-025 SHALL give flush priority over a simultaneous handshake or push.

Reset
REQ-026 SHALL clear the pointers, occupancy and half-select on rst; instr_valid=0, instr_data=0, instr_pc=0, instr_fault=0, and fetch_accept=1 once rst deasserts.
REQ-027 SHALL, if rst asserts mid-operation, discard all entries immediately without issuing any partial instruction.

Configuration
REQ-028 SHALL, when FETCH_UNPACK_STATS_EN is defined, add output port instr_count (32 bits): count of completed handshakes, reset to 0, cleared by rst only, wrapping from 0xFFFFFFFF to 0.
REQ-029 SHALL, without FETCH_UNPACK_STATS_EN, have neither the port nor the counter logic.

Structure
REQ-030 SHALL take the FIFO entry struct type and the half-select enum (HALF_LO, HALF_HI) from shared package biriscv_fetch_pkg.
REQ-031 SHALL implement storage in one sub-module, biriscv_fetch_fifo (generic push/pop FIFO), with the unpacking control in the top module.

Verification
REQ-032 SHALL cover: rst, then fetch 0x00000013_00100093 at PC 0x80000000 with ready=1 -> 0x00100093 at PC 0x80000000, then 0x00000013 at PC 0x80000004, on consecutive cycles.
REQ-033 SHALL cover: fetch at PC 0x80000004 -> a single instruction, data[63:32], at PC 0x80000004.
REQ-034 SHALL cover: DEPTH=2, ready=0, three valid fetches -> fetch_accept drops after two; outputs stable; the third word is accepted the cycle after two handshakes.
REQ-035 SHALL cover: fetch_error=1 at PC 0x1000 -> one instruction, fault=1, data 0, PC 0x1000; the next word issues normally.
REQ-036 SHALL cover: flush while two entries are held plus a push in the same cycle -> instr_valid=0 next cycle; the next fetch at 0x2000 issues first.
REQ-037 SHALL cover: with FETCH_UNPACK_STATS_EN, 5 handshakes -> instr_count=5; rst -> 0.
